// File: rtl/pc_sequencer.sv
// Multi-cycle control FSM that walks the PC unit through fetch, decode,
// execute and PC-update, with a watchdog on execute and a terminal HALT state.
module pc_sequencer #(
  parameter logic [3:0] HALT_OP  = 4'hF,
  parameter logic [3:0] JMP_OP   = 4'hD,
  parameter logic [3:0] BRZ_OP   = 4'hC,
  parameter logic [7:0] WDOG_MAX = 8'd200
) (
  input  logic        Clk2,
  input  logic        reset,
  input  logic        start,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic [15:0] ir,
  output logic        exec_start,
  input  logic        exec_done,
  input  logic        zero_flag,
  output logic        updatePC,
  output logic        jump,
  output logic [5:0]  offset,
  output logic        busy,
  output logic        halted,
  output logic        err
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_UPDATE = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [7:0]  wdog_q, wdog_d;
  logic        imem_req_q, imem_req_d;
  logic        exec_start_q, exec_start_d;
  logic        update_pc_q, update_pc_d;
  logic        jump_q, jump_d;
  logic        err_q, err_d;
  logic [3:0]  op;

  assign op = ir_q[15:12];

  // Strobes default low each cycle so every pulse lasts one cycle unless the
  // state explicitly re-asserts it (imem_req is held this way during FETCH).
  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    wdog_d       = wdog_q;
    err_d        = err_q;
    imem_req_d   = 1'b0;
    exec_start_d = 1'b0;
    update_pc_d  = 1'b0;
    jump_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_FETCH;
          imem_req_d = 1'b1;
        end
      end

      ST_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_data;
          state_d = ST_DECODE;
        end else begin
          imem_req_d = 1'b1;
        end
      end

      ST_DECODE: begin
        if (op == HALT_OP) begin
          state_d = ST_HALT;
        end else if (op == JMP_OP) begin
          state_d     = ST_UPDATE;
          update_pc_d = 1'b1;
          jump_d      = 1'b1;
        end else if (op == BRZ_OP) begin
          state_d     = ST_UPDATE;
          update_pc_d = 1'b1;
          jump_d      = zero_flag;
        end else begin
          state_d      = ST_EXEC;
          exec_start_d = 1'b1;
          wdog_d       = 8'd0;
        end
      end

      // Completion is checked before expiry so a done in the last cycle wins.
      ST_EXEC: begin
        wdog_d = wdog_q + 8'd1;
        if (exec_done) begin
          state_d     = ST_UPDATE;
          update_pc_d = 1'b1;
        end else if (wdog_q == WDOG_MAX - 8'd1) begin
          state_d = ST_HALT;
          err_d   = 1'b1;
        end
      end

      ST_UPDATE: begin
        state_d    = ST_FETCH;
        imem_req_d = 1'b1;
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk2) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ir_q         <= 16'd0;
      wdog_q       <= 8'd0;
      err_q        <= 1'b0;
      imem_req_q   <= 1'b0;
      exec_start_q <= 1'b0;
      update_pc_q  <= 1'b0;
      jump_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ir_q         <= ir_d;
      wdog_q       <= wdog_d;
      err_q        <= err_d;
      imem_req_q   <= imem_req_d;
      exec_start_q <= exec_start_d;
      update_pc_q  <= update_pc_d;
      jump_q       <= jump_d;
    end
  end

  assign imem_req   = imem_req_q;
  assign ir         = ir_q;
  assign exec_start = exec_start_q;
  assign updatePC   = update_pc_q;
  assign jump       = jump_q;
  assign err        = err_q;
  assign offset     = ir_q[5:0];
  assign busy       = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                      (state_q == ST_EXEC)  || (state_q == ST_UPDATE);
  assign halted     = (state_q == ST_HALT);

endmodule
